// File: rtl/sar_multichannel_ctrl_if.sv
// Handshake and analog-front-end bundle for the multi-channel SAR sequencer.
// The master side is the sequencer; the slave side is the front end plus the result consumer.
interface sar_multichannel_ctrl_if #(
    parameter int DATA    = 8,
    parameter int CH_BITS = 2
);
    logic               Enable;
    logic               Compare;
    logic [CH_BITS-1:0] ChanSel;
    logic               SampleEn;
    logic               ClockCmp;
    logic [DATA-1:0]    DacCode;
    logic [DATA-1:0]    DataOut;
    logic [CH_BITS-1:0] DataChan;
    logic               DataValid;
    logic               DataReady;
    logic               Busy;

    modport master (
        input  Enable, Compare, DataReady,
        output ChanSel, SampleEn, ClockCmp, DacCode, DataOut, DataChan, DataValid, Busy
    );

    modport slave (
        output Enable, Compare, DataReady,
        input  ChanSel, SampleEn, ClockCmp, DacCode, DataOut, DataChan, DataValid, Busy
    );
endinterface

// File: rtl/sar_multichannel_ctrl.sv
// Round-robin SAR ADC sequencer: mux select, sample/hold, binary search, tagged results.
// Optional macro SAR_TRACK_EN: per-channel tracking that re-resolves only TRACK_BITS low bits.
module sar_multichannel_ctrl #(
    parameter int DATA          = 8,
    parameter int CHANNELS      = 4,
    parameter int CH_BITS       = 2,
    parameter int SAMPLE_CYCLES = 2,
    parameter int TRACK_BITS    = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    sar_multichannel_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_STORE   = 2'd3
    } state_t;

    localparam logic [DATA-1:0]    SAR_MSB = {1'b1, {(DATA-1){1'b0}}};
    localparam logic [DATA-1:0]    SAR_LSB = {{(DATA-1){1'b0}}, 1'b1};
    localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(CHANNELS - 1);
    localparam logic [CH_BITS-1:0] ONE_CH  = CH_BITS'(1'b1);

    generate
        if (DATA < 4 || CHANNELS < 1 || SAMPLE_CYCLES < 1 || SAMPLE_CYCLES > 15 ||
            TRACK_BITS < 1 || TRACK_BITS >= DATA) begin : g_bad_params
            $error("sar_multichannel_ctrl: illegal parameter set");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_sample_cnt;
    logic [DATA-1:0]    r_sar;
    logic [DATA-1:0]    r_temp_sar;
    logic [CH_BITS-1:0] r_chan_sel;
    logic [DATA-1:0]    r_data_out;
    logic [CH_BITS-1:0] r_data_chan;
    logic               r_data_valid;

    logic               w_sample_last;
    logic               w_conv_last;
    logic               w_accept;
    logic [DATA-1:0]    w_cmp_bits;
    logic [DATA-1:0]    w_result;
    logic [DATA-1:0]    w_load_sar;
    logic [DATA-1:0]    w_load_temp;
    logic               w_track_hit;

    assign w_sample_last = (r_sample_cnt == 4'(SAMPLE_CYCLES - 1));
    assign w_conv_last   = (r_sar == SAR_LSB);
    assign w_accept      = r_data_valid & bus.DataReady;
    assign w_cmp_bits    = bus.Compare ? r_sar : {DATA{1'b0}};
    assign w_result      = r_temp_sar | w_cmp_bits;

`ifdef SAR_TRACK_EN
    localparam logic [DATA-1:0] TRACK_MSB  = SAR_LSB << (TRACK_BITS - 1);
    localparam logic [DATA-1:0] TRACK_MASK = {{(DATA-TRACK_BITS){1'b1}}, {TRACK_BITS{1'b0}}};

    logic [DATA-1:0]       r_last [CHANNELS];
    logic [CHANNELS-1:0]   r_locked;
    logic                  r_tracked;
    logic [TRACK_BITS-1:0] w_low;
    logic                  w_window_edge;

    assign w_low         = w_result[TRACK_BITS-1:0];
    assign w_window_edge = (w_low == {TRACK_BITS{1'b0}}) || (&w_low);

    // Starting point of the search: narrow window around the last result when locked
    always_comb begin
        w_track_hit = r_locked[r_chan_sel];
        if (w_track_hit) begin
            w_load_sar  = TRACK_MSB;
            w_load_temp = r_last[r_chan_sel] & TRACK_MASK;
        end else begin
            w_load_sar  = SAR_MSB;
            w_load_temp = {DATA{1'b0}};
        end
    end

    // Per-channel history; a tracked result on the window edge forces a full search next time
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < CHANNELS; i++) r_last[i] <= {DATA{1'b0}};
            r_locked  <= {CHANNELS{1'b0}};
            r_tracked <= 1'b0;
        end else if (r_state == ST_SAMPLE && w_sample_last) begin
            r_tracked <= w_track_hit;
        end else if (r_state == ST_CONVERT && w_conv_last) begin
            r_last[r_chan_sel]   <= w_result;
            r_locked[r_chan_sel] <= ~(r_tracked & w_window_edge);
        end else begin
            r_tracked <= r_tracked;
        end
    end
`else
    // Every conversion is a full binary search
    always_comb begin
        w_track_hit = 1'b0;
        w_load_sar  = SAR_MSB;
        w_load_temp = {DATA{1'b0}};
    end
`endif

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.Enable) w_next_state = ST_SAMPLE;
                else            w_next_state = ST_IDLE;
            end
            ST_SAMPLE: begin
                if (w_sample_last) w_next_state = ST_CONVERT;
                else               w_next_state = ST_SAMPLE;
            end
            ST_CONVERT: begin
                if (w_conv_last) w_next_state = ST_STORE;
                else             w_next_state = ST_CONVERT;
            end
            ST_STORE: begin
                if (w_accept) w_next_state = bus.Enable ? ST_SAMPLE : ST_IDLE;
                else          w_next_state = ST_STORE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Sample timing, successive approximation and result hand-off
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_sample_cnt <= 4'd0;
            r_sar        <= {DATA{1'b0}};
            r_temp_sar   <= {DATA{1'b0}};
            r_chan_sel   <= {CH_BITS{1'b0}};
            r_data_out   <= {DATA{1'b0}};
            r_data_chan  <= {CH_BITS{1'b0}};
            r_data_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_SAMPLE: begin
                    if (w_sample_last) begin
                        r_sample_cnt <= 4'd0;
                        r_sar        <= w_load_sar;
                        r_temp_sar   <= w_load_temp;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                    end
                end
                ST_CONVERT: begin
                    r_temp_sar <= w_result;
                    r_sar      <= r_sar >> 1;
                    if (w_conv_last) begin
                        r_data_out   <= w_result;
                        r_data_chan  <= r_chan_sel;
                        r_data_valid <= 1'b1;
                    end
                end
                ST_STORE: begin
                    if (w_accept) begin
                        r_data_valid <= 1'b0;
                        r_chan_sel   <= (r_chan_sel == LAST_CH) ? {CH_BITS{1'b0}} : r_chan_sel + ONE_CH;
                    end
                end
                default: begin
                    r_sample_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign bus.ChanSel   = r_chan_sel;
    assign bus.SampleEn  = (r_state == ST_SAMPLE);
    assign bus.ClockCmp  = (r_state == ST_CONVERT) & ~Clock;
    assign bus.DacCode   = (r_state == ST_CONVERT) ? (r_temp_sar | r_sar) : {DATA{1'b0}};
    assign bus.DataOut   = r_data_out;
    assign bus.DataChan  = r_data_chan;
    assign bus.DataValid = r_data_valid;
    assign bus.Busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_sar_multichannel_ctrl.sv
// Directed bench for sar_multichannel_ctrl with an ideal comparator model per channel.
module tb_sar_multichannel_ctrl;
    localparam int DATA     = 8;
    localparam int CHANNELS = 4;
    localparam int CH_BITS  = 2;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    sar_multichannel_ctrl_if #(.DATA(DATA), .CH_BITS(CH_BITS)) ifc ();

    sar_multichannel_ctrl #(
        .DATA(DATA), .CHANNELS(CHANNELS), .CH_BITS(CH_BITS),
        .SAMPLE_CYCLES(2), .TRACK_BITS(3)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (ifc)
    );

    logic [7:0] vin [CHANNELS];
    assign ifc.Compare = (vin[ifc.ChanSel] >= ifc.DacCode);

    int n_vec = 0;
    int n_err = 0;
    int n_cyc;
    int n_conv;
    logic [7:0] dac_exp [8];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Advance until DataValid (bounded), then check data/tag; reports cycles and compare samples
    task automatic collect(input string tag, input logic [7:0] exp_d, input logic [1:0] exp_c,
                           output int cyc, output int conv);
        cyc  = 0;
        conv = 0;
        do begin
            tick();
            cyc++;
            if (ifc.DacCode != 8'h00) conv++;
        end while (!ifc.DataValid && cyc < 60);
        check_val({tag, "_valid"}, 32'(ifc.DataValid), 32'd1);
        check_val({tag, "_data"},  32'(ifc.DataOut),   32'(exp_d));
        check_val({tag, "_chan"},  32'(ifc.DataChan),  32'(exp_c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        dac_exp = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        vin = '{8'hA5, 8'hFF, 8'h7F, 8'h80};
        ifc.Enable    = 1'b0;
        ifc.DataReady = 1'b1;
        #23;
        check_val("rst_busy",  32'(ifc.Busy),      32'd0);
        check_val("rst_valid", 32'(ifc.DataValid), 32'd0);
        check_val("rst_dac",   32'(ifc.DacCode),   32'd0);
        check_val("rst_samp",  32'(ifc.SampleEn),  32'd0);

        // Test 1: single full conversion of channel 0, latency and DAC sequence
        @(negedge Clock);
        Reset      = 1'b0;
        ifc.Enable = 1'b1;
        tick();
        check_val("t1_samp_e1", 32'(ifc.SampleEn), 32'd1);
        check_val("t1_busy_e1", 32'(ifc.Busy),     32'd1);
        tick();
        check_val("t1_samp_e2", 32'(ifc.SampleEn), 32'd1);
        tick();
        check_val("t1_samp_e3", 32'(ifc.SampleEn), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("t1_dac%0d", i), 32'(ifc.DacCode), 32'(dac_exp[i]));
            if (i == 0) begin
                @(negedge Clock);
                #1;
                check_val("t1_clkcmp", 32'(ifc.ClockCmp), 32'd1);
            end
            if (i < 7) tick();
        end
        check_val("t1_valid_e10", 32'(ifc.DataValid), 32'd0);
        tick();
        check_val("t1_valid_e11", 32'(ifc.DataValid), 32'd1);
        check_val("t1_data",      32'(ifc.DataOut),   32'hA5);
        check_val("t1_chan",      32'(ifc.DataChan),  32'd0);

`ifndef SAR_TRACK_EN
        // Test 2: continuous scan with wrap back to channel 0
        vin[0] = 8'h00;
        collect("t2_ch1", 8'hFF, 2'd1, n_cyc, n_conv);
        collect("t2_ch2", 8'h7F, 2'd2, n_cyc, n_conv);
        collect("t2_ch3", 8'h80, 2'd3, n_cyc, n_conv);
        collect("t2_ch0", 8'h00, 2'd0, n_cyc, n_conv);
        vin[1] = 8'hC3;
        tick();
        check_val("t2_adv", 32'(ifc.ChanSel), 32'd1);

        // Test 3: backpressure holds the result and stalls the scan
        ifc.DataReady = 1'b0;
        collect("t3_ch1", 8'hC3, 2'd1, n_cyc, n_conv);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val($sformatf("t3_hold_v%0d", i), 32'(ifc.DataValid), 32'd1);
            check_val($sformatf("t3_hold_d%0d", i), 32'(ifc.DataOut),   32'hC3);
            check_val($sformatf("t3_hold_s%0d", i), 32'(ifc.SampleEn),  32'd0);
            check_val($sformatf("t3_hold_c%0d", i), 32'(ifc.ChanSel),   32'd1);
        end
        ifc.DataReady = 1'b1;
        tick();
        check_val("t3_acc_valid", 32'(ifc.DataValid), 32'd0);
        check_val("t3_acc_chan",  32'(ifc.ChanSel),   32'd2);
        check_val("t3_acc_samp",  32'(ifc.SampleEn),  32'd1);

        // Test 4: reset in the middle of a conversion
        n_cyc = 0;
        while (ifc.DacCode == 8'h00 && n_cyc < 20) begin
            tick();
            n_cyc++;
        end
        repeat (3) tick();
        @(negedge Clock);
        #1;
        check_val("t4_pre_cmp", 32'(ifc.ClockCmp), 32'd1);
        Reset = 1'b1;
        #1;
        check_val("t4_dac",   32'(ifc.DacCode),   32'd0);
        check_val("t4_cmp",   32'(ifc.ClockCmp),  32'd0);
        check_val("t4_chsel", 32'(ifc.ChanSel),   32'd0);
        check_val("t4_busy",  32'(ifc.Busy),      32'd0);
        check_val("t4_dout",  32'(ifc.DataOut),   32'd0);
        check_val("t4_dchan", 32'(ifc.DataChan),  32'd0);
        check_val("t4_valid", 32'(ifc.DataValid), 32'd0);
        vin[0] = 8'h3C;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        collect("t4_fresh", 8'h3C, 2'd0, n_cyc, n_conv);
        check_val("t4_latency", 32'(n_cyc),  32'd11);
        check_val("t4_compares", 32'(n_conv), 32'd8);

        // Test 5: Enable dropped during SAMPLE still delivers, then idles
        tick();
        check_val("t5_samp", 32'(ifc.SampleEn), 32'd1);
        check_val("t5_ch",   32'(ifc.ChanSel),  32'd1);
        ifc.Enable = 1'b0;
        vin[1] = 8'h5A;
        collect("t5_ch1", 8'h5A, 2'd1, n_cyc, n_conv);
        tick();
        check_val("t5_busy",  32'(ifc.Busy),      32'd0);
        check_val("t5_next",  32'(ifc.ChanSel),   32'd2);
        check_val("t5_valid", 32'(ifc.DataValid), 32'd0);
        repeat (3) tick();
        check_val("t5_idle_busy", 32'(ifc.Busy),     32'd0);
        check_val("t5_idle_samp", 32'(ifc.SampleEn), 32'd0);
`else
        // Test 6: tracking narrows the search; a window-edge result forces a full search
        Reset = 1'b1;
        vin = '{8'hA5, 8'h11, 8'h22, 8'h33};
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        collect("t6_full", 8'hA5, 2'd0, n_cyc, n_conv);
        check_val("t6_full_n", 32'(n_conv), 32'd8);
        vin[0] = 8'hA6;
        for (int c = 1; c < 4; c++) collect($sformatf("t6_a_ch%0d", c), vin[c], 2'(c), n_cyc, n_conv);
        collect("t6_trk1", 8'hA6, 2'd0, n_cyc, n_conv);
        check_val("t6_trk1_n", 32'(n_conv), 32'd3);
        vin[0] = 8'hB0;
        for (int c = 1; c < 4; c++) collect($sformatf("t6_b_ch%0d", c), vin[c], 2'(c), n_cyc, n_conv);
        collect("t6_edge", 8'hA7, 2'd0, n_cyc, n_conv);
        check_val("t6_edge_n", 32'(n_conv), 32'd3);
        for (int c = 1; c < 4; c++) collect($sformatf("t6_c_ch%0d", c), vin[c], 2'(c), n_cyc, n_conv);
        collect("t6_refull", 8'hB0, 2'd0, n_cyc, n_conv);
        check_val("t6_refull_n", 32'(n_conv), 32'd8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
